// File: rtl/counter_worker.sv
// counter_worker: byte-loaded counting worker with synchronised async strobes.
// Bytes arrive on din under the shift strobe. The first byte lands in the MSB
// of da, and the last byte in the LSB of db. The final byte starts a run in the
// latched mode. The run ends on the cb==db limit (LIMIT/DOWN) or on a stop
// strobe (any mode).
module counter_worker #(
    parameter int WIDTH      = 16,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            shift,
    input  logic                                            stop,
    input  logic [7:0]                                      din,
    input  logic [1:0]                                      mode,
    input  logic [((WIDTH/8 > 1) ? $clog2(WIDTH/8) : 1)-1:0] rd_sel,
    output logic [7:0]                                      dout,
    output logic                                            run,
    output logic                                            done,
    output logic                                            overflow,
    output logic                                            loading
);

    localparam int NumBytes = WIDTH / 8;
    localparam int BcntW    = $clog2(2 * NumBytes);
    localparam logic [BcntW-1:0] BcntLast = BcntW'(2 * NumBytes - 1);

    typedef enum logic [1:0] {
        ModeLimit  = 2'd0,
        ModeStop   = 2'd1,
        ModeOffset = 2'd2,
        ModeDown   = 2'd3
    } mode_e;

    // Index 0 is shift, index 1 is stop.
    localparam int NumStrobes = 2;

    logic [NumStrobes-1:0] strobe_in;
    logic [SYNC_DEPTH-1:0] sync_q [NumStrobes];
    logic [NumStrobes-1:0] hist_q;
    logic [NumStrobes-1:0] arm_q;
    logic [NumStrobes-1:0] arm_d;
    logic [NumStrobes-1:0] pulse;
    // Marks synchroniser stages that hold a genuine post-reset sample.
    logic [SYNC_DEPTH-1:0] vld_q;

    logic shift_pulse;
    logic stop_pulse;

    logic [WIDTH-1:0] da_q, da_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] ca_q, ca_d;
    logic [WIDTH-1:0] cb_q, cb_d;
    logic [BcntW-1:0] bcnt_q, bcnt_d;
    mode_e            lmode_q, lmode_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH-1:0]   da_new;
    logic [WIDTH-1:0]   db_new;
    mode_e              mode_in;
    logic               limit_mode;
    logic               terminate;

    assign strobe_in = {stop, shift};

    // Synchroniser, history and arming flops for both strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NumStrobes; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
            arm_q  <= '0;
            vld_q  <= '0;
        end else begin
            for (int s = 0; s < NumStrobes; s++) begin
                sync_q[s] <= {sync_q[s][SYNC_DEPTH-2:0], strobe_in[s]};
            end
            for (int s = 0; s < NumStrobes; s++) begin
                hist_q[s] <= sync_q[s][SYNC_DEPTH-1];
            end
            arm_q <= arm_d;
            vld_q <= {vld_q[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    // A strobe only arms once a real low level has reached the last stage,
    // so a strobe held high across reset release does not pulse.
    always_comb begin
        arm_d = arm_q;
        pulse = '0;
        for (int s = 0; s < NumStrobes; s++) begin
            if (vld_q[SYNC_DEPTH-1] && !sync_q[s][SYNC_DEPTH-1]) begin
                arm_d[s] = 1'b1;
            end
            pulse[s] = sync_q[s][SYNC_DEPTH-1] & ~hist_q[s] & arm_q[s];
        end
    end

    assign shift_pulse = pulse[0];
    assign stop_pulse  = pulse[1];

    // The {da,db} pair shifts left a byte, with din entering at the bottom.
    assign shifted = ({da_q, db_q} << 8) | {{(2*WIDTH-8){1'b0}}, din};
    assign da_new  = shifted[2*WIDTH-1:WIDTH];
    assign db_new  = shifted[WIDTH-1:0];
    assign mode_in = mode_e'(mode);

    assign limit_mode = (lmode_q == ModeLimit) || (lmode_q == ModeDown);
    assign terminate  = stop_pulse || (limit_mode && (cb_q == db_q));

    // Next state for load, run and termination. The terminate check comes
    // before the count so that ca and cb hold their values on the final cycle.
    always_comb begin
        da_d    = da_q;
        db_d    = db_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        bcnt_d  = bcnt_q;
        lmode_d = lmode_q;
        run_d   = run_q;
        done_d  = done_q;
        ovf_d   = ovf_q;

        if (run_q) begin
            if (terminate) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                cb_d = cb_q + WIDTH'(1);
                if (&cb_q) begin
                    ovf_d = 1'b1;
                end
                if (lmode_q == ModeDown) begin
                    ca_d = ca_q - WIDTH'(1);
                end else begin
                    ca_d = ca_q + WIDTH'(1);
                end
            end
        end else if (shift_pulse) begin
            da_d = da_new;
            db_d = db_new;
            if (bcnt_q == '0) begin
                done_d = 1'b0;
            end
            if (bcnt_q == BcntLast) begin
                bcnt_d  = '0;
                run_d   = 1'b1;
                cb_d    = '0;
                ovf_d   = 1'b0;
                lmode_d = mode_in;
                if (mode_in == ModeOffset) begin
                    ca_d = da_new + db_new;
                end else begin
                    ca_d = da_new;
                end
            end else begin
                bcnt_d = bcnt_q + BcntW'(1);
            end
        end
    end

    // Datapath and control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            da_q    <= '0;
            db_q    <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            bcnt_q  <= '0;
            lmode_q <= ModeLimit;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            da_q    <= da_d;
            db_q    <= db_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            bcnt_q  <= bcnt_d;
            lmode_q <= lmode_d;
            run_q   <= run_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Byte readback of ca. Out-of-range indices read as zero.
    always_comb begin
        dout = 8'h00;
        for (int i = 0; i < NumBytes; i++) begin
            if (int'(rd_sel) == i) begin
                dout = ca_q[8*i +: 8];
            end
        end
    end

    assign run      = run_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign loading  = (bcnt_q != '0);

endmodule

// File: tb/tb_counter_worker.sv
// Bench for counter_worker (WIDTH=16, SYNC_DEPTH=2). Its expected values come
// from a mode-level model of the final ca value and the run length.
module tb_counter_worker;

    localparam int W = 16;

    logic       clk;
    logic       rst;
    logic       shift;
    logic       stop;
    logic [7:0] din;
    logic [1:0] mode;
    logic [0:0] rd_sel;
    logic [7:0] dout;
    logic       run;
    logic       done;
    logic       overflow;
    logic       loading;

    int errors = 0;
    int checks = 0;
    int run_total = 0;

    counter_worker #(
        .WIDTH     (W),
        .SYNC_DEPTH(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .shift   (shift),
        .stop    (stop),
        .din     (din),
        .mode    (mode),
        .rd_sel  (rd_sel),
        .dout    (dout),
        .run     (run),
        .done    (done),
        .overflow(overflow),
        .loading (loading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the cycles in which run is high.
    always @(posedge clk) begin
        if (run) run_total <= run_total + 1;
    end

    // Final ca after a run of L cycles, taken from the mode rules.
    function automatic logic [W-1:0] model_ca(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [1:0] m, input int len);
        case (m)
            2'd0:    return a + b;
            2'd1:    return a + W'(len - 1);
            2'd2:    return a + b + W'(len - 1);
            default: return a - b;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] m);
        din = b;
        mode = m;
        shift = 1'b1;
        tick(4);
        shift = 1'b0;
        tick(4);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick(4);
        stop = 1'b0;
        tick(4);
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                        output int base);
        base = run_total;
        send_byte(a[15:8], m);
        send_byte(a[7:0], m);
        send_byte(b[15:8], m);
        send_byte(b[7:0], m);
    endtask

    task automatic wait_done(input int limit, input string name);
        int n;
        n = 0;
        while ((run || !done) && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (run || !done) begin
            errors++;
            $display("FAIL %s: timeout, run=%0b done=%0b required run=0 done=1", name, run, done);
        end
    endtask

    task automatic read_ca(output logic [W-1:0] v);
        rd_sel = 1'b0;
        #1;
        v[7:0] = dout;
        rd_sel = 1'b1;
        #1;
        v[15:8] = dout;
        rd_sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++;
        if ({run, done, overflow, loading} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {run, done, overflow, loading});
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h required 00", dout);
        end
    endtask

    task automatic test_limit();
        int base, len;
        logic [W-1:0] ca;
        load(16'h1234, 16'h0005, 2'd0, base);
        wait_done(100, "limit_done");
        len = run_total - base;
        checks++;
        if (len !== 6) begin
            errors++;
            $display("FAIL limit_len: got %0d required %0d", len, 6);
        end
        read_ca(ca);
        checks++;
        if (ca !== model_ca(16'h1234, 16'h0005, 2'd0, len)) begin
            errors++;
            $display("FAIL limit_ca: got %h required %h", ca, model_ca(16'h1234, 16'h5, 2'd0, len));
        end
        rd_sel = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h12) begin
            errors++;
            $display("FAIL limit_dout1: got %h required 12", dout);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL limit_ovf: got %b required 0", overflow);
        end
        rd_sel = 1'b0;
        tick(1);
    endtask

    task automatic test_zero_limit();
        int base, len;
        logic [W-1:0] ca;
        load(16'h00AB, 16'h0000, 2'd0, base);
        wait_done(50, "zero_done");
        len = run_total - base;
        read_ca(ca);
        checks++;
        if (len !== 1 || ca !== 16'h00AB) begin
            errors++;
            $display("FAIL zero_limit: got len=%0d ca=%h required len=1 ca=00ab", len, ca);
        end
        tick(1);
    endtask

    task automatic test_down();
        int base, len;
        logic [W-1:0] ca;
        base = run_total;
        send_byte(8'h01, 2'd3);
        // A first byte clears the previous run's done.
        checks++;
        if (done !== 1'b0 || loading !== 1'b1) begin
            errors++;
            $display("FAIL down_first_byte: got done=%b loading=%b required done=0 loading=1",
                     done, loading);
        end
        send_byte(8'h00, 2'd3);
        send_byte(8'h00, 2'd3);
        send_byte(8'h03, 2'd3);
        wait_done(50, "down_done");
        len = run_total - base;
        read_ca(ca);
        checks++;
        if (len !== 4 || ca !== model_ca(16'h0100, 16'h0003, 2'd3, len)) begin
            errors++;
            $display("FAIL down: got len=%0d ca=%h required len=4 ca=%h", len, ca,
                     model_ca(16'h0100, 16'h0003, 2'd3, 4));
        end
        tick(1);
    endtask

    task automatic test_offset_stop();
        int base, len, n;
        logic [W-1:0] ca;
        load(16'h0010, 16'h0020, 2'd2, base);
        // Raising stop after 7 run cycles makes the pulse land in the 10th cycle.
        n = 0;
        while (run_total - base < 7 && n < 100) begin
            tick(1);
            n++;
        end
        pulse_stop();
        wait_done(50, "offset_done");
        len = run_total - base;
        read_ca(ca);
        checks++;
        if (len !== 10 || ca !== model_ca(16'h0010, 16'h0020, 2'd2, len)) begin
            errors++;
            $display("FAIL offset_stop: got len=%0d ca=%h required len=10 ca=0039", len, ca);
        end
        pulse_stop();
        read_ca(ca);
        checks++;
        if (ca !== 16'h0039 || done !== 1'b1 || run !== 1'b0) begin
            errors++;
            $display("FAIL idle_stop: got ca=%h done=%b run=%b required ca=0039 done=1 run=0",
                     ca, done, run);
        end
        tick(1);
    endtask

    task automatic test_held_shift();
        int base, len;
        logic [W-1:0] ca;
        base = run_total;
        din = 8'h00;
        mode = 2'd0;
        shift = 1'b1;
        tick(50);
        shift = 1'b0;
        tick(4);
        checks++;
        if (loading !== 1'b1) begin
            errors++;
            $display("FAIL held_shift_one: got loading=%b required 1", loading);
        end
        send_byte(8'h00, 2'd0);
        send_byte(8'h00, 2'd0);
        checks++;
        if (run !== 1'b0 || loading !== 1'b1) begin
            errors++;
            $display("FAIL held_shift_three: got run=%b loading=%b required run=0 loading=1",
                     run, loading);
        end
        send_byte(8'h20, 2'd0);
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL held_shift_start: got run=%b required 1", run);
        end
        wait_done(100, "held_done");
        len = run_total - base;
        read_ca(ca);
        checks++;
        if (len !== 33 || ca !== model_ca(16'h0000, 16'h0020, 2'd0, len)) begin
            errors++;
            $display("FAIL held_shift_run: got len=%0d ca=%h required len=33 ca=0020", len, ca);
        end
        tick(1);
    endtask

    task automatic test_shift_during_run();
        int base, len;
        logic [W-1:0] ca;
        load(16'h0100, 16'h0040, 2'd0, base);
        repeat (3) send_byte(8'hFF, 2'd1);
        wait_done(200, "busy_done");
        len = run_total - base;
        read_ca(ca);
        checks++;
        if (len !== 65 || ca !== model_ca(16'h0100, 16'h0040, 2'd0, len) || loading !== 1'b0) begin
            errors++;
            $display("FAIL shift_during_run: got len=%0d ca=%h loading=%b required 65 0140 0",
                     len, ca, loading);
        end
        tick(1);
    endtask

    task automatic test_random();
        int base, len, target, n;
        logic [1:0] m;
        logic [W-1:0] a, b, ca;
        for (int it = 0; it < 8; it++) begin
            m = 2'($urandom_range(0, 3));
            a = W'($urandom);
            b = (m == 2'd0 || m == 2'd3) ? W'($urandom_range(0, 200)) : W'($urandom);
            load(a, b, m, base);
            if (m == 2'd1 || m == 2'd2) begin
                target = $urandom_range(8, 40);
                n = 0;
                while (run_total - base < target && n < 100) begin
                    tick(1);
                    n++;
                end
                pulse_stop();
            end
            wait_done(400, "rand_done");
            len = run_total - base;
            read_ca(ca);
            checks++;
            if (ca !== model_ca(a, b, m, len) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL rand_ca: mode=%0d a=%h b=%h got ca=%h ovf=%b required ca=%h ovf=0",
                         m, a, b, ca, overflow, model_ca(a, b, m, len));
            end
            if (m == 2'd0 || m == 2'd3) begin
                checks++;
                if (len !== int'(b) + 1) begin
                    errors++;
                    $display("FAIL rand_len: mode=%0d got %0d required %0d", m, len, int'(b) + 1);
                end
            end
            tick(1);
        end
    endtask

    task automatic test_overflow();
        int base, len, n;
        logic [W-1:0] ca;
        load(16'h0000, 16'h0000, 2'd1, base);
        n = 0;
        while (run_total - base < 70000 && n < 71000) begin
            tick(1);
            n++;
        end
        pulse_stop();
        wait_done(50, "ovf_done");
        len = run_total - base;
        read_ca(ca);
        checks++;
        if (overflow !== 1'b1 || ca !== model_ca(16'h0000, 16'h0000, 2'd1, len)) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b ca=%h required ovf=1 ca=%h", overflow, ca,
                     model_ca(16'h0000, 16'h0000, 2'd1, len));
        end
        load(16'h0000, 16'h0010, 2'd0, base);
        checks++;
        if (overflow !== 1'b0 || run !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear: got ovf=%b run=%b required ovf=0 run=1", overflow, run);
        end
        wait_done(100, "ovf2_done");
        tick(1);
    endtask

    task automatic test_rst_mid_run();
        int base;
        load(16'h1111, 16'h0000, 2'd1, base);
        tick(10);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({run, done, overflow, loading} !== 4'b0000 || dout !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_run: got flags=%b dout=%h required 0000 00",
                     {run, done, overflow, loading}, dout);
        end
        // shift is held high across the reset release and must not load.
        din = 8'h55;
        shift = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);
        checks++;
        if (loading !== 1'b0) begin
            errors++;
            $display("FAIL rst_held_strobe: got loading=%b required 0", loading);
        end
        shift = 1'b0;
        tick(4);
        send_byte(8'h55, 2'd0);
        checks++;
        if (loading !== 1'b1) begin
            errors++;
            $display("FAIL rst_rearm: got loading=%b required 1", loading);
        end
    endtask

    initial begin
        rst = 1'b1;
        shift = 1'b0;
        stop = 1'b0;
        din = 8'h00;
        mode = 2'd0;
        rd_sel = 1'b0;
        test_reset();
        test_limit();
        test_zero_limit();
        test_down();
        test_offset_stop();
        test_held_shift();
        test_shift_during_run();
        test_random();
        test_overflow();
        test_rst_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
